// File: rtl/ex_div_pkg.sv
// ============================================================================
// Module  : ex_div_pkg
// Purpose : Shared types and constants for the sequential EX-stage divider.
//           Holds the FSM state encoding and the op[1:0] encodings.
// Ports   : none (package)
// Macros  : DATA_SIZE - default operand width (32 if not defined elsewhere)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package ex_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    // op[0] = 1 selects unsigned, op[1] = 1 selects remainder
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

endpackage

`default_nettype wire

// File: rtl/ex_div_step.sv
// ============================================================================
// Module  : ex_div_step
// Purpose : One combinational restoring-division step. Shifts the next
//           dividend bit into the partial remainder and subtracts the divisor
//           when it fits.
// Ports   : rem_in       - current partial remainder (XLEN)
//           dividend_bit - next dividend bit, MSB first
//           divisor      - divisor magnitude (XLEN)
//           rem_out      - next partial remainder (XLEN)
//           q_bit        - quotient bit produced by this step
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0]   w_partial;
    logic [XLEN-1:0] w_diff;

    assign w_partial = {rem_in, dividend_bit};
    // When the divisor fits, the true difference is below the divisor and
    // therefore fits in XLEN bits, so the low-order subtraction is exact.
    assign w_diff    = w_partial[XLEN-1:0] - divisor;
    assign q_bit     = (w_partial >= {1'b0, divisor});
    assign rem_out   = q_bit ? w_diff : w_partial[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/ex_div_seq.sv
// ============================================================================
// Module  : ex_div_seq
// Purpose : Multi-cycle restoring divider for the EX stage (DIV/DIVU/REM/REMU).
//           One quotient bit per cycle; signs are applied in a final FIX cycle.
// Ports   : clk      - clock, rising edge
//           rst      - synchronous active-high reset
//           start    - request a new divide (sampled in IDLE only)
//           op       - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//           rs1_data - dividend, rs2_data - divisor
//           flush    - abort; no done is produced
//           busy     - state is not IDLE
//           stall    - EX-stage hold request
//           done     - one-cycle result-valid pulse
//           result   - quotient/remainder, held until overwritten
// Macros  : EX_DIV_EARLY_OUT_EN - divide-by-zero and signed overflow skip the
//           iterative phase and finish two cycles after start.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_div_seq
    import ex_div_pkg::*;
#(
    parameter int XLEN = `DATA_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN + 1);

    div_state_t        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;       // dividend shifts out MSB-first, quotient in
    logic [XLEN-1:0]   r_divisor;
    logic [XLEN-1:0]   r_result;
    logic              r_is_rem;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_done;

    logic              w_is_signed;
    logic              w_sign_a;
    logic              w_sign_b;
    logic              w_div_zero;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN-1:0]   w_next_rem;
    logic              w_q_bit;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;

    assign w_is_signed = ~op[0];
    assign w_sign_a    = w_is_signed & rs1_data[XLEN-1];
    assign w_sign_b    = w_is_signed & rs2_data[XLEN-1];
    assign w_mag_a     = w_sign_a ? -rs1_data : rs1_data;
    assign w_mag_b     = w_sign_b ? -rs2_data : rs2_data;
    assign w_div_zero  = (rs2_data == '0);

`ifdef EX_DIV_EARLY_OUT_EN
    localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    logic w_ovf;
    assign w_ovf = w_is_signed & (rs1_data == C_INT_MIN) & (rs2_data == '1);
`endif

    ex_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_in       (r_rem),
        .dividend_bit (r_quo[XLEN-1]),
        .divisor      (r_divisor),
        .rem_out      (w_next_rem),
        .q_bit        (w_q_bit)
    );

    assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_is_rem  <= op[1];
                            // Divide-by-zero quotient is all ones regardless of
                            // dividend sign, so it must never be negated. The
                            // unsigned core already yields all ones and the
                            // dividend magnitude as remainder in that case.
                            r_neg_q   <= (w_sign_a ^ w_sign_b) & ~w_div_zero;
                            r_neg_r   <= w_sign_a;
                            r_rem     <= '0;
                            r_quo     <= w_mag_a;
                            r_divisor <= w_mag_b;
                            r_count   <= CNT_W'(XLEN);
                            r_state   <= ST_CALC;
`ifdef EX_DIV_EARLY_OUT_EN
                            // Preload the values the iterative core would
                            // produce and skip straight to sign fix-up.
                            if (w_div_zero) begin
                                r_quo   <= '1;
                                r_rem   <= w_mag_a;
                                r_state <= ST_FIX;
                            end else if (w_ovf) begin
                                r_quo   <= C_INT_MIN;
                                r_rem   <= '0;
                                r_state <= ST_FIX;
                            end
`endif
                        end
                    end
                    ST_CALC: begin
                        r_rem   <= w_next_rem;
                        r_quo   <= {r_quo[XLEN-2:0], w_q_bit};
                        r_count <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign stall  = (r_state == ST_CALC) || (r_state == ST_FIX) ||
                    ((r_state == ST_IDLE) && start && !flush && !rst);
    assign done   = r_done;
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_ex_div_seq.sv
// ============================================================================
// Module  : tb_ex_div_seq
// Purpose : Directed self-checking bench for ex_div_seq (XLEN = 32).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_div_seq;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

`ifdef EX_DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_div_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .result   (result)
    );

    // Issue one operation at cycle t and follow it until done (bounded).
    // lat = cycles from acceptance to done (-1 on timeout). stall_ok records
    // whether stall was high from t up to done and low in the done cycle.
    // If noise_at > 0, a stray start is driven in cycle t+noise_at.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int noise_at,
                         output int lat, output logic [31:0] res,
                         output bit stall_ok);
        @(negedge clk);
        start = 1'b1; op = o; rs1_data = a; rs2_data = b;
        #1;
        stall_ok = (stall === 1'b1);
        lat = -1;
        res = 'x;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == noise_at) begin
                start = 1'b1; op = DIVU; rs1_data = 32'd50; rs2_data = 32'd5;
            end
            #1;
            if (done === 1'b1) begin
                lat = k;
                res = result;
                if (stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stall !== 1'b1) stall_ok = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; flush = 1'b1; op = DIVU;
        rs1_data = 32'd9; rs2_data = 32'd3;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        rst = 1'b0; start = 1'b0; flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_divu();
        int lat; logic [31:0] res; bit sok;
        do_op(DIVU, 32'd100, 32'd7, 0, lat, res, sok);
        n_cmp++; if (lat != 34) begin n_fail++; $display("FAIL divu_latency: got %0d want 34", lat); end
        n_cmp++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_result: got %h want %h", res, 32'd14); end
        n_cmp++; if (!sok) begin n_fail++; $display("FAIL divu_stall: got 0 want 1 (stall profile)"); end
    endtask

    task automatic test_signed();
        int lat; logic [31:0] res; bit sok;
        do_op(REM, 32'hFFFF_FFF9, 32'd2, 0, lat, res, sok);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_neg: got %h want ffffffff", res); end
        do_op(DIV, 32'hFFFF_FFF9, 32'd2, 0, lat, res, sok);
        n_cmp++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg: got %h want fffffffd", res); end
        do_op(DIVU, 32'hFFFF_FFF9, 32'd2, 0, lat, res, sok);
        n_cmp++; if (res !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL divu_big: got %h want 7ffffffc", res); end
        do_op(REMU, 32'hFFFF_FFF9, 32'd2, 0, lat, res, sok);
        n_cmp++; if (res !== 32'h1) begin n_fail++; $display("FAIL remu_big: got %h want 1", res); end
        do_op(DIV, 32'd7, 32'hFFFF_FFFE, 0, lat, res, sok);
        n_cmp++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negdivisor: got %h want fffffffd", res); end
        do_op(REM, 32'd7, 32'hFFFF_FFFE, 0, lat, res, sok);
        n_cmp++; if (res !== 32'h1) begin n_fail++; $display("FAIL rem_negdivisor: got %h want 1", res); end
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] res; bit sok;
        do_op(DIV, 32'hFFFF_FFF9, 32'd0, 0, lat, res, sok);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divzero_div: got %h want ffffffff", res); end
        n_cmp++; if (lat != SPECIAL_LAT) begin n_fail++; $display("FAIL divzero_latency: got %0d want %0d", lat, SPECIAL_LAT); end
        n_cmp++; if (!sok) begin n_fail++; $display("FAIL divzero_stall: got 0 want 1 (stall profile)"); end
        do_op(REMU, 32'd5, 32'd0, 0, lat, res, sok);
        n_cmp++; if (res !== 32'd5) begin n_fail++; $display("FAIL divzero_remu: got %h want 5", res); end
        n_cmp++; if (lat != SPECIAL_LAT) begin n_fail++; $display("FAIL divzero_remu_latency: got %0d want %0d", lat, SPECIAL_LAT); end
        do_op(REM, 32'hFFFF_FFF9, 32'd0, 0, lat, res, sok);
        n_cmp++; if (res !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL divzero_rem: got %h want fffffff9", res); end
        do_op(DIVU, 32'd123, 32'd0, 0, lat, res, sok);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divzero_divu: got %h want ffffffff", res); end
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] res; bit sok;
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, res, sok);
        n_cmp++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_div: got %h want 80000000", res); end
        n_cmp++; if (lat != SPECIAL_LAT) begin n_fail++; $display("FAIL ovf_latency: got %0d want %0d", lat, SPECIAL_LAT); end
        do_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, res, sok);
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("FAIL ovf_rem: got %h want 0", res); end
        // Same bit pattern unsigned is an ordinary full-latency divide
        do_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, res, sok);
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("FAIL ovf_divu: got %h want 0", res); end
        n_cmp++; if (lat != 34) begin n_fail++; $display("FAIL ovf_divu_latency: got %0d want 34", lat); end
    endtask

    task automatic test_start_ignored();
        int lat; logic [31:0] res; bit sok;
        do_op(DIVU, 32'd100, 32'd7, 3, lat, res, sok);
        n_cmp++; if (lat != 34) begin n_fail++; $display("FAIL ignore_latency: got %0d want 34", lat); end
        n_cmp++; if (res !== 32'd14) begin n_fail++; $display("FAIL ignore_result: got %h want %h", res, 32'd14); end
    endtask

    task automatic test_flush();
        int  seen_done;
        // Previous result is 14 from test_start_ignored.
        // Flush wins over a simultaneous start in IDLE.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = DIVU; rs1_data = 32'd1000; rs2_data = 32'd3;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_start_stall: got %b want 0", stall); end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b want 0", busy); end

        // Flush mid-CALC at t+10, with stray starts during CALC.
        @(negedge clk);
        start = 1'b1; op = DIVU; rs1_data = 32'd1000; rs2_data = 32'd3;
        seen_done = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = k[0];
            if (k == 10) begin start = 1'b0; flush = 1'b1; end
            #1;
            if (done === 1'b1) seen_done++;
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) seen_done++;
        end
        n_cmp++; if (seen_done != 0) begin n_fail++; $display("FAIL flush_done: got %0d pulses want 0", seen_done); end
        n_cmp++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result: got %h want %h", result, 32'd14); end
    endtask

    task automatic test_reset_mid();
        int  seen_done;
        int  lat;
        @(negedge clk);
        start = 1'b1; op = DIVU; rs1_data = 32'd100; rs2_data = 32'd7;
        seen_done = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 5) rst = 1'b1;
            #1;
        end
        // Cycle t+6: reset was applied at t+5, start still high.
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", stall); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
        n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h want 0", result); end
        // First cycle after reset deasserts: start (still high) is accepted.
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept_stall: got %b want 1", stall); end
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done === 1'b1) begin lat = k; break; end
        end
        n_cmp++; if (lat != 34) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 34", lat); end
        n_cmp++; if (result !== 32'd14) begin n_fail++; $display("FAIL rstmid_result_new: got %h want %h", result, 32'd14); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = DIV;
        rs1_data = '0; rs2_data = '0;
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_overflow();
        test_start_ignored();
        test_flush();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
